gpio_pad_arbiter: RTL and testbench

//  Shares the GPIO pad bank between N_REQ drivers: requester 0 (GPIO regblock out/dir) is the background owner.

---
 rtl/gpio_pad_arbiter.sv | 162 ++++++++++++++++
 tb/tb_gpio_pad_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_arbiter.sv
// GPIO pad bank arbiter: requester 0 owns the bank by default, requesters 1..N_REQ-1
// claim it round-robin, and every handover tristates the bank for TURNAROUND cycles.
module gpio_pad_arbiter #(
  parameter int unsigned N_PADS     = 11,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n_sync,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*N_PADS-1:0]   req_out,
  input  logic [N_REQ*N_PADS-1:0]   req_oe,
  output logic [N_REQ-1:0]          gnt,
  output logic [2:0]                owner,
  output logic [N_PADS-1:0]         padout,
  output logic [N_PADS-1:0]         padoe
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned TURN_W = (TURNAROUND > 2) ? $clog2(TURNAROUND) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
  localparam logic [IDX_W-1:0]  RR_RST    = IDX_W'(N_REQ - 1);

  typedef enum logic {
    ST_OWN  = 1'b0,
    ST_TURN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_PADS-1:0]   padout_q, padout_d;
  logic [N_PADS-1:0]   padoe_q, padoe_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;

  logic [IDX_W-1:0]    target;
  logic                go_turn;
  logic                own_req;
  logic                any_other;
  logic                any_req;

  // Round-robin search over requesters 1..N_REQ-1 starting after ptr; excl=0 means no exclusion.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDX_W-1:0] ptr,
                                            input logic [IDX_W-1:0] excl);
    logic [N_REQ-1:0] hit;
    logic [N_REQ-1:0] sh;
    logic [IDX_W-1:0] res;
    logic             found;
    int unsigned      k;
    hit   = r & ~N_REQ'(1) & ~(N_REQ'(1) << excl);
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ - 1; i++) begin
      k  = ((32'(ptr) + i) % (N_REQ - 1)) + 32'd1;
      sh = hit >> k;
      if (!found && sh[0]) begin
        found = 1'b1;
        res   = IDX_W'(k);
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    padout_d   = padout_q;
    padoe_d    = padoe_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    target     = owner_q;
    go_turn    = 1'b0;

    own_req   = |(req & (N_REQ'(1) << owner_q));
    any_req   = |(req & ~N_REQ'(1));
    any_other = |(req & ~N_REQ'(1) & ~(N_REQ'(1) << owner_q));

    if (state_q == ST_OWN) begin
      padout_d = N_PADS'(req_out >> (32'(owner_q) * N_PADS));
      padoe_d  = N_PADS'(req_oe  >> (32'(owner_q) * N_PADS));
      if (owner_q == '0) begin
        if (any_req) begin
          go_turn = 1'b1;
          target  = pick(req, rr_ptr_q, '0);
        end
      end else if (!own_req) begin
        go_turn = 1'b1;
        target  = pick(req, rr_ptr_q, owner_q);
      end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && any_other) begin
        go_turn = 1'b1;
        target  = pick(req, rr_ptr_q, owner_q);
      end

      if (go_turn) begin
        state_d    = ST_TURN;
        owner_d    = target;
        gnt_d      = '0;
        padout_d   = padout_q;
        padoe_d    = '0;
        turn_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end else begin
      padoe_d = '0;
      gnt_d   = '0;
      if (turn_cnt_q == TURN_LAST) begin
        // A pending owner that gave up during the window is replaced without a second turnaround.
        if ((owner_q != '0) && !own_req) begin
          target = pick(req, rr_ptr_q, '0);
        end
        state_d    = ST_OWN;
        owner_d    = target;
        gnt_d      = N_REQ'(1) << target;
        padout_d   = N_PADS'(req_out >> (32'(target) * N_PADS));
        padoe_d    = N_PADS'(req_oe  >> (32'(target) * N_PADS));
        hold_cnt_d = '0;
        if (target != '0) begin
          rr_ptr_d = target;
        end
      end else begin
        turn_cnt_d = turn_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q    <= ST_OWN;
      owner_q    <= '0;
      gnt_q      <= N_REQ'(1);
      padout_q   <= '0;
      padoe_q    <= '0;
      rr_ptr_q   <= RR_RST;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      padout_q   <= padout_d;
      padoe_q    <= padoe_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign padout = padout_q;
  assign padoe  = padoe_q;

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Directed bench for gpio_pad_arbiter: instance a uses defaults, instance b uses
// TURNAROUND=2 and MAX_HOLD=8 for the pre-emption scenario.
module tb_gpio_pad_arbiter;

  localparam int unsigned NP = 11;
  localparam int unsigned NR = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*NP-1:0]  req_out;
  logic [NR*NP-1:0]  req_oe;
  logic [NR-1:0]     gnt_a, gnt_b;
  logic [2:0]        owner_a, owner_b;
  logic [NP-1:0]     padout_a, padoe_a, padout_b, padoe_b;

  logic [NP-1:0]     e_out [NR];
  logic [NP-1:0]     e_oe  [NR];
  int                seq   [4];
  int                errors = 0;
  int                checks = 0;

  gpio_pad_arbiter #(.N_PADS(NP), .N_REQ(NR), .TURNAROUND(1), .MAX_HOLD(0)) u_dut_a (
    .clk(clk), .rst_n_sync(rst_n), .req(req), .req_out(req_out), .req_oe(req_oe),
    .gnt(gnt_a), .owner(owner_a), .padout(padout_a), .padoe(padoe_a)
  );

  gpio_pad_arbiter #(.N_PADS(NP), .N_REQ(NR), .TURNAROUND(2), .MAX_HOLD(8)) u_dut_b (
    .clk(clk), .rst_n_sync(rst_n), .req(req), .req_out(req_out), .req_oe(req_oe),
    .gnt(gnt_b), .owner(owner_b), .padout(padout_b), .padoe(padoe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic own_a(input string tag, input int k);
    check({tag, "/a_gnt"},    16'(gnt_a),    16'(NR'(1) << k));
    check({tag, "/a_owner"},  16'(owner_a),  16'(k));
    check({tag, "/a_padout"}, 16'(padout_a), 16'(e_out[k]));
    check({tag, "/a_padoe"},  16'(padoe_a),  16'(e_oe[k]));
  endtask

  task automatic turn_a(input string tag, input int k, input logic [NP-1:0] held);
    check({tag, "/a_gnt"},    16'(gnt_a),    16'h0);
    check({tag, "/a_owner"},  16'(owner_a),  16'(k));
    check({tag, "/a_padout"}, 16'(padout_a), 16'(held));
    check({tag, "/a_padoe"},  16'(padoe_a),  16'h0);
  endtask

  task automatic own_b(input string tag, input int k);
    check({tag, "/b_gnt"},    16'(gnt_b),    16'(NR'(1) << k));
    check({tag, "/b_owner"},  16'(owner_b),  16'(k));
    check({tag, "/b_padout"}, 16'(padout_b), 16'(e_out[k]));
    check({tag, "/b_padoe"},  16'(padoe_b),  16'(e_oe[k]));
  endtask

  task automatic turn_b(input string tag, input int k, input logic [NP-1:0] held);
    check({tag, "/b_gnt"},    16'(gnt_b),    16'h0);
    check({tag, "/b_owner"},  16'(owner_b),  16'(k));
    check({tag, "/b_padout"}, 16'(padout_b), 16'(held));
    check({tag, "/b_padoe"},  16'(padoe_b),  16'h0);
  endtask

  task automatic rst_a(input string tag);
    check({tag, "/a_gnt"},    16'(gnt_a),    16'h1);
    check({tag, "/a_owner"},  16'(owner_a),  16'h0);
    check({tag, "/a_padout"}, 16'(padout_a), 16'h0);
    check({tag, "/a_padoe"},  16'(padoe_a),  16'h0);
  endtask

  initial begin
    e_out[0] = 11'h155; e_oe[0] = 11'h7FF;
    e_out[1] = 11'h2AA; e_oe[1] = 11'h00F;
    e_out[2] = 11'h0F0; e_oe[2] = 11'h3C3;
    e_out[3] = 11'h70F; e_oe[3] = 11'h555;
    for (int k = 0; k < NR; k++) begin
      req_out[k*NP +: NP] = e_out[k];
      req_oe[k*NP +: NP]  = e_oe[k];
    end
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 1;

    rst_n = 1'b0;
    req   = '0;
    step;
    step;
    rst_a("reset");
    check("reset/b_gnt",   16'(gnt_b),   16'h1);
    check("reset/b_padoe", 16'(padoe_b), 16'h0);

    // Background owner drives the pads one edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    step;
    own_a("idle", 0);
    own_b("idle", 0);

    req = 4'b0001;
    step;
    own_a("req0_ignored", 0);

    // Request from 2 with the bank idle.
    req = 4'b0100;
    step;
    turn_a("claim2_turn", 2, e_out[0]);
    step;
    own_a("claim2_own", 2);

    // Release by 2 and request by 1 on the same edge: single turnaround, never via 0.
    req = 4'b0010;
    step;
    turn_a("swap_turn", 1, e_out[2]);
    step;
    own_a("swap_own", 1);

    req = 4'b0000;
    step;
    turn_a("release_turn", 0, e_out[1]);
    step;
    own_a("release_own", 0);

    // Fresh reset, then round-robin 1,2,3,1 with each owner keeping the bank 4 cycles.
    rst_n = 1'b0;
    #1;
    rst_a("rst_async");
    #2;
    rst_n = 1'b1;
    req = 4'b1110;
    step;
    turn_a("rr_first_turn", 1, 11'h0);
    for (int i = 0; i < 4; i++) begin
      step;
      own_a($sformatf("rr%0d_own", i), seq[i]);
      repeat (3) begin
        step;
        own_a($sformatf("rr%0d_hold", i), seq[i]);
      end
      if (i < 3) begin
        req[seq[i]] = 1'b0;
        step;
        turn_a($sformatf("rr%0d_turn", i), seq[i+1], e_out[seq[i]]);
        req[seq[i]] = 1'b1;
      end
    end
    req = 4'b0000;
    step;
    turn_a("rr_end_turn", 0, e_out[1]);
    step;
    own_a("rr_end_own", 0);

    // Reset asserted mid-turnaround with request 3 pending.
    req = 4'b1000;
    step;
    turn_a("mid_turn", 3, e_out[0]);
    rst_n = 1'b0;
    #1;
    rst_a("mid_turn_rst");
    #2;
    rst_n = 1'b1;
    step;
    turn_a("rearb_turn", 3, 11'h0);
    step;
    own_a("rearb_own", 3);

    // MAX_HOLD=8 pre-emption on instance b (TURNAROUND=2).
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 4'b0010;
    step;
    turn_b("hold_turn0", 1, 11'h0);
    step;
    turn_b("hold_turn1", 1, 11'h0);
    step;
    own_b("hold_own", 1);
    req = 4'b1010;
    repeat (7) begin
      step;
      own_b("hold_keep", 1);
    end
    step;
    turn_b("preempt_turn0", 3, e_out[1]);
    step;
    turn_b("preempt_turn1", 3, e_out[1]);
    step;
    own_b("preempt_own", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
